clk_pll_seq: RTL and testbench

PLL reset/lock sequencer for the baseband clock generator. The 50 MHz `refclk` domain drives the PLL's active-high reset and filters its `locked` flag. It releases a single registered domain reset only after lock has been continuously stable, and restarts the PLL on lock loss, timeout or software request. Downstream 20 MHz and 80 MHz domains re-synchronise `dom_rst_n` locally.

---
 rtl/clk_pll_seq_pkg.sv | 24 ++
 rtl/clk_sync_bit.sv | 41 ++++
 rtl/clk_pll_seq.sv | 176 +++++++++++++++++
 tb/tb_clk_pll_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pll_seq_pkg.sv
// clk_pll_seq_pkg
// Shared definitions for the PLL reset/lock sequencer:
//   - pll_state_e : sequencer state with fixed 3-bit encodings 0..4
//   - RELOCK_W    : width of the saturating lock-loss counter
//   - max3        : constant function used to size the shared down-counter
package clk_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } pll_state_e;

  localparam int RELOCK_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_sync_bit.sv
// clk_sync_bit
// Multi-flop synchroniser for a single asynchronous status bit.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low clear of every stage
//   d     : asynchronous input bit
//   q     : synchronised output (STAGES edges of latency)
module clk_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] stage_in;

  // Stage 0 samples the raw input, every later stage samples its predecessor.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = d;
      end else begin : g_next
        assign stage_in[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= stage_in;
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/clk_pll_seq.sv
// clk_pll_seq
// PLL reset/lock sequencer in the refclk domain. Pulses the PLL reset,
// waits for a filtered lock, demands STABLE_CYCLES of continuous lock and
// then releases the downstream domain reset. Lock loss, lock timeout and
// software requests restart the PLL; repeated timeouts park in FAULT.
// Ports:
//   refclk       : free-running reference clock (sole clock)
//   rst_n        : asynchronous active-low reset
//   pll_locked   : PLL lock flag, asynchronous to refclk
//   soft_rst_req : single-cycle restart request
//   pll_rst      : PLL reset, active high
//   dom_rst_n    : downstream domain reset, active low
//   ready        : high while in RUN
//   fault        : high while in FAULT
//   relock_cnt   : saturating count of lock losses seen in RUN
//   state_o      : current state encoding
module clk_pll_seq
  import clk_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                soft_rst_req,
  output logic                pll_rst,
  output logic                dom_rst_n,
  output logic                ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic [2:0]          state_o
);

  localparam int CNT_W   = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // The counter is loaded with N-1 on entry so the exit fires on the N-th
  // edge spent in the state.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);

  logic                locked_s;
  pll_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [RETRY_W-1:0]  retry_reg, retry_next;
  logic [RELOCK_W-1:0] relock_reg, relock_next;
  logic                load_next;
  logic                cnt_zero;
  logic                pll_rst_reg, dom_rst_n_reg, ready_reg, fault_reg;

  clk_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  function automatic logic [CNT_W-1:0] cnt_load(input pll_state_e s);
    case (s)
      ST_ASSERT_RST: cnt_load = RST_LOAD;
      ST_WAIT_LOCK:  cnt_load = TIMEOUT_LOAD;
      ST_STABILIZE:  cnt_load = STABLE_LOAD;
      default:       cnt_load = '0;
    endcase
  endfunction

  assign cnt_zero = (cnt_reg == '0);

  always_comb begin
    state_next  = state_reg;
    retry_next  = retry_reg;
    relock_next = relock_reg;
    load_next   = 1'b0;

    if (state_reg == ST_RUN && !locked_s) begin
      // Lock loss in RUN outranks a coincident soft request so it is counted.
      state_next = ST_ASSERT_RST;
      load_next  = 1'b1;
      if (relock_reg != '1) begin
        relock_next = relock_reg + RELOCK_W'(1);
      end
    end else if (soft_rst_req) begin
      state_next = ST_ASSERT_RST;
      retry_next = '0;
      load_next  = 1'b1;
    end else begin
      case (state_reg)
        ST_ASSERT_RST: begin
          if (cnt_zero) begin
            state_next = ST_WAIT_LOCK;
            load_next  = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = ST_STABILIZE;
            load_next  = 1'b1;
          end else if (cnt_zero) begin
            retry_next = retry_reg + RETRY_W'(1);
            load_next  = 1'b1;
            if (int'(retry_reg) + 1 >= MAX_RETRY) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_ASSERT_RST;
            end
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            state_next = ST_WAIT_LOCK;
            load_next  = 1'b1;
          end else if (cnt_zero) begin
            state_next = ST_RUN;
            retry_next = '0;
            load_next  = 1'b1;
          end
        end
        ST_RUN, ST_FAULT: begin
          state_next = state_reg;
        end
        default: begin
          // Encodings 5..7 cannot be reached functionally; recover safely.
          state_next = ST_ASSERT_RST;
          load_next  = 1'b1;
        end
      endcase
    end

    if (load_next) begin
      cnt_next = cnt_load(state_next);
    end else if (!cnt_zero) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end else begin
      cnt_next = cnt_reg;
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as state_o.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_ASSERT_RST;
      cnt_reg       <= RST_LOAD;
      retry_reg     <= '0;
      relock_reg    <= '0;
      pll_rst_reg   <= 1'b1;
      dom_rst_n_reg <= 1'b0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      relock_reg    <= relock_next;
      pll_rst_reg   <= (state_next == ST_ASSERT_RST) || (state_next == ST_FAULT);
      dom_rst_n_reg <= (state_next == ST_RUN);
      ready_reg     <= (state_next == ST_RUN);
      fault_reg     <= (state_next == ST_FAULT);
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign dom_rst_n  = dom_rst_n_reg;
  assign ready      = ready_reg;
  assign fault      = fault_reg;
  assign relock_cnt = relock_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_clk_pll_seq.sv
// tb_clk_pll_seq
// Self-checking bench for clk_pll_seq. A behavioural model tracks the state,
// time spent in it and the delayed lock flag, and every cycle's outputs are
// compared against it. Directed scenarios add explicit timing checks;
// a randomized phase exercises lock toggling, soft requests and resets.
module tb_clk_pll_seq;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int SS = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst, dom_rst_n, ready, fault;
  logic [7:0] relock_cnt;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 refclk = ~refclk;

  clk_pll_seq #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR),
    .SYNC_STAGES   (SS)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .dom_rst_n    (dom_rst_n),
    .ready        (ready),
    .fault        (fault),
    .relock_cnt   (relock_cnt),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 assert, 1 wait, 2 stabilize, 3 run, 4 fault.
  int m_state, m_age, m_retry, m_relock;
  bit m_hist[SS];  // m_hist[SS-1] is the lock flag the sequencer currently sees

  task automatic model_reset();
    m_state = 0; m_age = 0; m_retry = 0; m_relock = 0;
    for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    int nxt;
    bit moved;
    ls = m_hist[SS-1];
    nxt = m_state;
    moved = 1'b0;
    if (m_state == 3 && !ls) begin
      if (m_relock < 255) m_relock++;
      nxt = 0; moved = 1'b1;
    end else if (soft_rst_req) begin
      m_retry = 0; nxt = 0; moved = 1'b1;
    end else begin
      case (m_state)
        0: if (m_age + 1 == RC) begin nxt = 1; moved = 1'b1; end
        1: if (ls) begin nxt = 2; moved = 1'b1; end
           else if (m_age + 1 == LT) begin
             m_retry++;
             nxt = (m_retry >= MR) ? 4 : 0;
             moved = 1'b1;
           end
        2: if (!ls) begin nxt = 1; moved = 1'b1; end
           else if (m_age + 1 == SC) begin m_retry = 0; nxt = 3; moved = 1'b1; end
        default: ;
      endcase
    end
    if (nxt != m_state)
      $display("[TB] %0t state %0d -> %0d relock=%0d retry=%0d", $time, m_state, nxt, m_relock, m_retry);
    m_age = moved ? 0 : m_age + 1;
    m_state = nxt;
    for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pll_locked;
  endtask

  task automatic compare_all();
    check("state",     state_o,    m_state);
    check("pll_rst",   pll_rst,    (m_state == 0 || m_state == 4));
    check("dom_rst_n", dom_rst_n,  (m_state == 3));
    check("ready",     ready,      (m_state == 3));
    check("fault",     fault,      (m_state == 4));
    check("relock",    relock_cnt, m_relock);
  endtask

  // One clock: the model sees the same inputs as the DUT at the edge, outputs
  // are compared on the following falling edge.
  task automatic step();
    @(posedge refclk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge refclk);
    compare_all();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag, output int n);
    n = 0;
    while (state_o !== 3'(target) && n < budget) begin
      step();
      n++;
    end
    check(tag, state_o, target);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_state"},  state_o,    0);
    check({tag, "_pllrst"}, pll_rst,    1);
    check({tag, "_domrst"}, dom_rst_n,  0);
    check({tag, "_ready"},  ready,      0);
    check({tag, "_fault"},  fault,      0);
    check({tag, "_relock"}, relock_cnt, 0);
    model_reset();
  endtask

  int n, r0;

  initial begin
    model_reset();
    repeat (2) @(negedge refclk);
    compare_all();

    // Power-up lock
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 20) begin step(); n++; end
    check("pwr_rst_len", n, RC);
    step();
    pll_locked = 1'b1;
    n = 0;
    while (state_o != 3'd2 && n < 20) begin step(); n++; end
    check("lock_to_stab", n, SS + 1);
    n = 0;
    while (!dom_rst_n && n < 40) begin step(); n++; end
    check("stab_len", n, SC);
    check("ready_up", ready, 1);

    // Lock loss in RUN
    pll_locked = 1'b0;
    n = 0;
    while (dom_rst_n && n < 20) begin step(); n++; end
    check("loss_to_rst", n, SS + 1);
    check("loss_pllrst", pll_rst, 1);
    check("loss_relock", relock_cnt, 1);
    pll_locked = 1'b1;
    wait_state(2, 40, "relock_stab", n);

    // Lock glitch in STABILIZE
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_state(1, 10, "glitch_wait", n);
    wait_state(2, 10, "glitch_stab", n);
    n = 0;
    while (state_o != 3'd3 && n < 40) begin step(); n++; end
    check("glitch_restab_len", n, SC);

    // Timeout to fault
    pll_locked = 1'b0;
    wait_state(1, 40, "to_wait1", n);
    n = 0;
    while (state_o == 3'd1 && n < 60) begin step(); n++; end
    check("to_window1", n, LT);
    check("to_retry_state", state_o, 0);
    wait_state(1, 40, "to_wait2", n);
    n = 0;
    while (state_o == 3'd1 && n < 60) begin step(); n++; end
    check("to_window2", n, LT);
    check("to_fault_state", state_o, 4);
    check("to_fault_flag", fault, 1);
    check("to_fault_pllrst", pll_rst, 1);
    repeat (3) step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check("soft_exit_state", state_o, 0);
    check("soft_exit_fault", fault, 0);
    check("soft_exit_pllrst", pll_rst, 1);

    // Lock loss and soft request on the same edge in RUN
    pll_locked = 1'b1;
    wait_state(3, 60, "sim_run", n);
    r0 = int'(relock_cnt);
    pll_locked = 1'b0;
    step();
    step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check("sim_relock", relock_cnt, r0 + 1);
    check("sim_state", state_o, 0);

    // Saturation of relock_cnt
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      wait_state(3, 60, "sat_run", n);
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      wait_state(0, 10, "sat_loss", n);
    end
    check("sat_relock", relock_cnt, 255);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      soft_rst_req = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) begin
        soft_rst_req = 1'b0;
        async_reset_check("rand_rst");
        step();
        rst_n = 1'b1;
      end
      step();
    end
    soft_rst_req = 1'b0;

    // Reset in the middle of STABILIZE
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    pll_locked = 1'b1;
    wait_state(2, 60, "mid_stab", n);
    repeat (2) step();
    async_reset_check("mid_rst");
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 20) begin step(); n++; end
    check("mid_rst_len", n, RC);
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
